// File: rtl/lp_ser_pkg.sv
// Shared definitions for the low-power tree serializer.
//   ser_state_e : IDLE (no word shifting) / RUN (word shifting out)
//   MAX_WIDTH   : widest supported parallel word
//   width_ok()  : legal WIDTH check (power of two, 4..64)
//   bit_rev()   : reverse the low w bits of a MAX_WIDTH vector
package lp_ser_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MIN_WIDTH = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ser_state_e;

  function automatic bit width_ok(int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

  // Bits at and above w are returned as zero; callers truncate to their width.
  function automatic logic [MAX_WIDTH-1:0] bit_rev(logic [MAX_WIDTH-1:0] v,
                                                   int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    logic [5:0]           src;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) begin
        src         = 6'(w - 1 - i);
        r[i[5:0]]   = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lp_tree_serializer_n_mux.sv
// Balanced WIDTH:1 multiplexer built from log2(WIDTH) levels of 2:1 muxes.
//   data : WIDTH-bit input vector
//   sel  : log2(WIDTH)-bit index; level k (counted from the leaves) uses sel[k]
//   out  : data[sel]
module lp_mux_tree
  import lp_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] sel,
  output logic                     out
);

  localparam int unsigned LVLS = $clog2(WIDTH);

  // Level k holds WIDTH>>k nodes; level 0 is the leaves, level LVLS the root.
  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    logic [(WIDTH>>k)-1:0] n;
    if (k == 0) begin : g_leaf
      assign n = data;
    end else begin : g_node
      for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_mux
        assign n[j] = sel[k-1] ? g_lvl[k-1].n[2*j+1] : g_lvl[k-1].n[2*j];
      end
    end
  end

  assign out = g_lvl[LVLS].n[0];

endmodule

// File: rtl/lp_tree_serializer_n.sv
// Low-power tree serializer: WIDTH-bit words in over valid/ready, one bit per
// CLK out through a mux tree indexed by a bit counter.
//   CLK, RESET   : clock (rising edge), asynchronous active-low reset
//   VPWR, VGND   : supply pins; outputs are held low unless VPWR=1, VGND=0
//   PAR_IN       : parallel word, bit 0 = LSB
//   MSB_FIRST    : captured with PAR_IN; 1 sends bit WIDTH-1 first
//   IN_VALID     : PAR_IN/MSB_FIRST valid
//   IN_READY     : one-word holding buffer is empty
//   SERIAL_OUT   : registered serial bit (0 when idle)
//   OUT_VALID    : SERIAL_OUT carries a data bit
//   FRAME        : high with the first bit of each word
module lp_tree_serializer_n
  import lp_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire              VPWR,
  inout  wire              VGND,
  input  logic [WIDTH-1:0] PAR_IN,
  input  logic             MSB_FIRST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SERIAL_OUT,
  output logic             OUT_VALID,
  output logic             FRAME
);

  localparam int unsigned        CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lp_tree_serializer_n: WIDTH must be a power of two in 4..64");
  end

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_msb_q, hold_msb_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             ov_q, ov_d;
  logic             frame_q, frame_d;

  logic             busy;
  logic             last_bit;
  logic             accept;
  logic             load;
  logic             tree_out;
  logic             pwr_ok;

  assign pwr_ok = VPWR & ~VGND;

  lp_mux_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .data (act_q),
    .sel  (cnt_q),
    .out  (tree_out)
  );

  always_comb begin
    busy       = (state_q == S_RUN);
    last_bit   = (cnt_q == LAST);
    // IN_READY is low while the buffer is full, so accept and load are exclusive.
    accept     = IN_VALID && IN_READY;
    load       = hold_v_q && (!busy || last_bit);

    state_d    = state_q;
    hold_d     = hold_q;
    hold_msb_d = hold_msb_q;
    hold_v_d   = hold_v_q;
    act_d      = act_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: if (load) state_d = S_RUN;
      S_RUN:  if (last_bit && !hold_v_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      hold_d     = PAR_IN;
      hold_msb_d = MSB_FIRST;
      hold_v_d   = 1'b1;
    end else if (load) begin
      hold_v_d   = 1'b0;
    end

    // Reversing on load lets the tree always walk ACT from index 0 upward.
    if (load) begin
      act_d = hold_msb_q ? WIDTH'(bit_rev(MAX_WIDTH'(hold_q), WIDTH)) : hold_q;
      cnt_d = '0;
    end else if (busy) begin
      // Wraps to 0 on the last bit, which is also the idle value.
      cnt_d = cnt_q + 1'b1;
    end

    ser_d   = busy ? tree_out : 1'b0;
    ov_d    = busy;
    frame_d = busy && (cnt_q == '0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      hold_msb_q <= 1'b0;
      hold_v_q   <= 1'b0;
      act_q      <= '0;
      cnt_q      <= '0;
      ser_q      <= 1'b0;
      ov_q       <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_msb_q <= hold_msb_d;
      hold_v_q   <= hold_v_d;
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      ser_q      <= ser_d;
      ov_q       <= ov_d;
      frame_q    <= frame_d;
    end
  end

  assign IN_READY   = !hold_v_q && pwr_ok;
  assign SERIAL_OUT = ser_q && pwr_ok;
  assign OUT_VALID  = ov_q && pwr_ok;
  assign FRAME      = frame_q && pwr_ok;

endmodule

// File: tb/tb_lp_tree_serializer_n.sv
module tb_lp_tree_serializer_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  wire  vpwr;
  wire  vgnd;
  assign vpwr = 1'b1;
  assign vgnd = 1'b0;

  logic [15:0] par16;
  logic [7:0]  par8;
  logic [1:0]  msb;
  logic [1:0]  vld;
  logic rdy0, so0, ov0, fr0;
  logic rdy1, so1, ov1, fr1;

  lp_tree_serializer_n #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .RESET(rst_n), .VPWR(vpwr), .VGND(vgnd),
    .PAR_IN(par16), .MSB_FIRST(msb[0]), .IN_VALID(vld[0]),
    .IN_READY(rdy0), .SERIAL_OUT(so0), .OUT_VALID(ov0), .FRAME(fr0)
  );

  lp_tree_serializer_n #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RESET(rst_n), .VPWR(vpwr), .VGND(vgnd),
    .PAR_IN(par8), .MSB_FIRST(msb[1]), .IN_VALID(vld[1]),
    .IN_READY(rdy1), .SERIAL_OUT(so1), .OUT_VALID(ov1), .FRAME(fr1)
  );

  // Reference model: each accepted word is a record with its accept edge t
  // and load edge s. Bit k of that word is on the output after edge s+1+k;
  // the buffer is full (not ready) after edges t..s-1.
  typedef struct {
    int          t;
    int          s;
    logic [63:0] w;
    bit          m;
  } rec_t;

  rec_t recs [2][128];
  int   nrec [2];
  int   e;
  int   n_vec;
  int   n_err;
  bit   accepted [2];
  bit   cap [$];

  function automatic int wd(int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic bit m_ready(int d, int x);
    for (int i = 0; i < nrec[d]; i++)
      if (recs[d][i].t <= x && x < recs[d][i].s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_out(int d, int x, output bit v, output bit b, output bit f);
    int w;
    w = wd(d);
    v = 1'b0; b = 1'b0; f = 1'b0;
    for (int i = 0; i < nrec[d]; i++) begin
      int s;
      s = recs[d][i].s;
      if (x > s && x <= s + w) begin
        int k;
        int idx;
        k   = x - s - 1;
        idx = recs[d][i].m ? (w - 1 - k) : k;
        v   = 1'b1;
        f   = (k == 0);
        b   = recs[d][i].w[idx];
      end
    end
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic check_all();
    bit v, b, f;
    logic [3:0] obs;
    for (int d = 0; d < 2; d++) begin
      m_out(d, e, v, b, f);
      obs = (d == 0) ? {rdy0, so0, ov0, fr0} : {rdy1, so1, ov1, fr1};
      check($sformatf("w%0d.in_ready", wd(d)), obs[3], m_ready(d, e));
      check($sformatf("w%0d.serial_out", wd(d)), obs[2], b);
      check($sformatf("w%0d.out_valid", wd(d)), obs[1], v);
      check($sformatf("w%0d.frame", wd(d)), obs[0], f);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      accepted[d] = rst_n && vld[d] && m_ready(d, e - 1);
      if (accepted[d] && nrec[d] < 128) begin
        int s;
        s = e + 1;
        if (nrec[d] > 0 && recs[d][nrec[d]-1].s + wd(d) > s)
          s = recs[d][nrec[d]-1].s + wd(d);
        recs[d][nrec[d]] = '{t: e, s: s,
                             w: (d == 0) ? 64'(par16) : 64'(par8), m: msb[d]};
        nrec[d]++;
      end
    end
    #1;
    if (ov0) cap.push_back(so0);
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(int d, logic [15:0] w, bit m);
    if (d == 0) par16 = w; else par8 = w[7:0];
    msb[d] = m;
    vld[d] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (accepted[d]) return;
    end
    check($sformatf("w%0d.accept_timeout", wd(d)), accepted[d], 1'b1);
    vld[d] = 1'b0;
  endtask

  task automatic check_capture(string tag, bit msb_first, logic [15:0] exp);
    logic [15:0] val;
    val = '0;
    check({tag, ".nbits"}, cap.size(), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++)
      if (msb_first) val[15 - i] = cap[i]; else val[i] = cap[i];
    check(tag, val, exp);
    cap.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; e = 0;
    nrec[0] = 0; nrec[1] = 0;
    par16 = '0; par8 = '0; msb = '0; vld = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all();
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Single word, LSB first and MSB first.
    cap.delete();
    send(0, 16'hC5AF, 1'b0); vld[0] = 1'b0;
    idle(20);
    check_capture("c5af_lsb_first", 1'b0, 16'hC5AF);
    send(0, 16'hC5AF, 1'b1); vld[0] = 1'b0;
    idle(20);
    check_capture("c5af_msb_first", 1'b1, 16'hC5AF);

    // IN_VALID held across two words: gapless 32-bit stream.
    send(0, 16'hFFFF, 1'b0);
    send(0, 16'h0000, 1'b0);
    vld[0] = 1'b0;
    idle(36);

    // Three words back to back: third stalls until the first completes.
    send(0, 16'($urandom), 1'($urandom));
    send(0, 16'($urandom), 1'($urandom));
    send(0, 16'($urandom), 1'($urandom));
    vld[0] = 1'b0;
    msb[0] = ~msb[0];
    idle(52);

    // Reset at bit 7 of 16'hA5A5 with a second word queued.
    send(0, 16'hA5A5, 1'b0);
    send(0, 16'h5A5A, 1'b1);
    vld[0] = 1'b0;
    idle(7);
    rst_n = 1'b0;
    nrec[0] = 0; nrec[1] = 0;
    #1 check_all();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(0, 16'h0001, 1'b0); vld[0] = 1'b0;
    idle(20);

    // WIDTH=8: 8'hA5 in both orders.
    send(1, 16'h00A5, 1'b0); vld[1] = 1'b0;
    idle(12);
    send(1, 16'h00A5, 1'b1); vld[1] = 1'b0;
    idle(12);

    // Random words with random gaps and order, both widths.
    for (int i = 0; i < 30; i++) begin
      int d;
      d = (i % 3 == 0) ? 0 : 1;
      idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 20));
      send(d, 16'($urandom), 1'($urandom));
      vld[d] = $urandom_range(0, 1) == 1;
      if (!vld[d]) begin
        par16 = 16'($urandom); par8 = 8'($urandom);
      end
      msb[d] = 1'($urandom);
    end
    vld = '0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
